// File: rtl/fft_stream_checker.sv
// fft_stream_checker: finds the latency between a parallel FFT output stream and its golden
// stream by searching for golden word 0, then compares NLANES complex lanes per word within TOL.
// Build option: define FFT_CHK_FIRST_ERR_EN to capture the first LOCKED mismatch on first_err_o.
module fft_stream_checker #(
    parameter int unsigned NBITS_out = 10,
    parameter int unsigned NLANES    = 4,
    parameter int unsigned N         = 128,
    parameter int unsigned MAX_LAT   = 64,
    parameter int unsigned TOL       = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                start_i,
    input  logic [NLANES*2*NBITS_out-1:0]                       dut_data_i,
    input  logic                                                exp_valid_i,
    input  logic [NLANES*2*NBITS_out-1:0]                       exp_data_i,
    output logic                                                exp_ready_o,
    output logic                                                locked_o,
    output logic                                                done_o,
    output logic                                                fail_o,
    output logic [$clog2(MAX_LAT+1)-1:0]                        latency_o,
    output logic [NLANES*CNT_W-1:0]                             lane_err_o,
    output logic [CNT_W-1:0]                                    frame_cnt_o,
    output logic [$clog2(N)+$clog2(NLANES)+4*NBITS_out-1:0]     first_err_o
);
    localparam int unsigned W     = NBITS_out;
    localparam int unsigned W1    = NBITS_out + 1;
    localparam int unsigned Words = N / NLANES;
    localparam int unsigned WidxW = (Words > 1) ? $clog2(Words) : 1;
    localparam int unsigned LatW  = $clog2(MAX_LAT + 1);

    localparam logic [LatW-1:0]  LatMax   = LatW'(MAX_LAT);
    localparam logic [WidxW-1:0] WidxLast = WidxW'(Words - 1);
    localparam logic [W:0]       TolW     = W1'(TOL);

    typedef enum logic [2:0] {StIdle, StSearch, StLocked, StDone, StFail} state_e;

    state_e                       state_q;
    logic [LatW-1:0]              latency_q;
    logic [WidxW-1:0]             widx_q;
    logic [CNT_W-1:0]             frame_q;
    logic [NLANES-1:0][CNT_W-1:0] lane_err_q;
    logic [NLANES-1:0]            err_q;
    logic [NLANES-1:0]            lane_bad;
    logic                         match;
    logic                         consume;

    // Difference in W+1 bits cannot wrap, so its magnitude is exact.
    function automatic logic comp_bad(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        logic [W:0] mag;
        d   = {a[W-1], a} - {b[W-1], b};
        mag = d[W] ? -d : d;
        return mag > TolW;
    endfunction

    // Per-lane mismatch of both components; unknown DUT bits count as a mismatch in simulation.
    always_comb begin
        lane_bad = '0;
        for (int k = 0; k < int'(NLANES); k++) begin
            lane_bad[k] = comp_bad(dut_data_i[k*2*W+W +: W], exp_data_i[k*2*W+W +: W]) |
                          comp_bad(dut_data_i[k*2*W +: W], exp_data_i[k*2*W +: W]);
`ifndef SYNTHESIS
            if ($isunknown(dut_data_i[k*2*W +: 2*W])) lane_bad[k] = 1'b1;
`endif
        end
    end

    assign match       = exp_valid_i && (lane_bad == '0);
    assign consume     = (state_q == StSearch && match) || (state_q == StLocked && exp_valid_i);
    assign exp_ready_o = (state_q == StLocked) || (state_q == StSearch && match);

    // Alignment FSM, word/frame tracking and delayed per-lane error counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            latency_q  <= '0;
            widx_q     <= '0;
            frame_q    <= '0;
            lane_err_q <= '0;
            err_q      <= '0;
        end else if (start_i) begin
            state_q    <= StSearch;
            latency_q  <= '0;
            widx_q     <= '0;
            frame_q    <= '0;
            lane_err_q <= '0;
            err_q      <= '0;
        end else begin
            // Flags from the previous compare are counted in any state, so a flag
            // raised on the last LOCKED word still lands after the move to DONE.
            err_q <= '0;
            for (int k = 0; k < int'(NLANES); k++) begin
                if (err_q[k] && lane_err_q[k] != '1) begin
                    lane_err_q[k] <= lane_err_q[k] + CNT_W'(1);
                end
            end
            if (consume) begin
                if (widx_q == WidxLast) begin
                    widx_q <= '0;
                    if (frame_q != '1) frame_q <= frame_q + CNT_W'(1);
                end else begin
                    widx_q <= widx_q + WidxW'(1);
                end
            end
            case (state_q)
                StSearch: begin
                    if (match) begin
                        state_q <= StLocked;
                    end else begin
                        latency_q <= latency_q + LatW'(1);
                        if (latency_q + LatW'(1) == LatMax) state_q <= StFail;
                    end
                end
                StLocked: begin
                    if (exp_valid_i) err_q   <= lane_bad;
                    else             state_q <= StDone;
                end
                default: ;
            endcase
        end
    end

    assign locked_o    = (state_q == StLocked);
    assign done_o      = (state_q == StDone);
    assign fail_o      = (state_q == StFail);
    assign latency_o   = latency_q;
    assign lane_err_o  = lane_err_q;
    assign frame_cnt_o = frame_q;

`ifdef FFT_CHK_FIRST_ERR_EN
    localparam int unsigned IdxW  = $clog2(N);
    localparam int unsigned LaneW = $clog2(NLANES);
    localparam int unsigned FeW   = IdxW + LaneW + 4 * W;

    logic           fe_valid_q;
    logic [FeW-1:0] first_err_q;
    logic [FeW-1:0] fe_word;
    logic           fe_hit;

    // Descending scan so the lowest mismatching lane is the one kept.
    always_comb begin
        fe_hit  = 1'b0;
        fe_word = '0;
        for (int k = int'(NLANES) - 1; k >= 0; k--) begin
            if (lane_bad[k]) begin
                fe_hit  = 1'b1;
                fe_word = {IdxW'(widx_q) * IdxW'(NLANES) + IdxW'(k), LaneW'(k),
                           dut_data_i[k*2*W +: 2*W], exp_data_i[k*2*W +: 2*W]};
            end
        end
    end

    // Capture the first LOCKED mismatch and hold it until start or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            fe_valid_q  <= 1'b0;
            first_err_q <= '0;
        end else if (state_q == StLocked && exp_valid_i && fe_hit && !fe_valid_q) begin
            fe_valid_q  <= 1'b1;
            first_err_q <= fe_word;
        end
    end

    assign first_err_o = first_err_q;
`else
    assign first_err_o = '0;
`endif

endmodule

// File: tb/tb_fft_stream_checker.sv
// Bench for fft_stream_checker: random golden frames, a delayed and optionally corrupted DUT
// stream, and a word-level reference model of lock timing, error counts and flags.
// Two checkers (TOL=0 and TOL=1) watch the same streams.
module tb_fft_stream_checker;
    localparam int W       = 10;
    localparam int L       = 4;
    localparam int DW      = 80;
    localparam int NW      = 96;
    localparam int MAX_LAT = 64;
    localparam int CNT_W   = 16;
    localparam int LAT_W   = 7;
    localparam int FE_W    = 49;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [DW-1:0] dut_data;
    logic          exp_valid;
    logic [DW-1:0] exp_data;

    logic             rdy0, lk0, dn0, fl0, rdy1, lk1, dn1, fl1;
    logic [LAT_W-1:0] lat0, lat1;
    logic [L*CNT_W-1:0] le0, le1;
    logic [CNT_W-1:0] fc0, fc1;
    logic [FE_W-1:0]  fe0, fe1;

    fft_stream_checker #(.TOL(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dut_data_i(dut_data),
        .exp_valid_i(exp_valid), .exp_data_i(exp_data), .exp_ready_o(rdy0),
        .locked_o(lk0), .done_o(dn0), .fail_o(fl0), .latency_o(lat0),
        .lane_err_o(le0), .frame_cnt_o(fc0), .first_err_o(fe0)
    );

    fft_stream_checker #(.TOL(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dut_data_i(dut_data),
        .exp_valid_i(exp_valid), .exp_data_i(exp_data), .exp_ready_o(rdy1),
        .locked_o(lk1), .done_o(dn1), .fail_o(fl1), .latency_o(lat1),
        .lane_err_o(le1), .frame_cnt_o(fc1), .first_err_o(fe1)
    );

    logic [DW-1:0] gold [NW];
    logic [DW-1:0] dutw [NW];
    logic [DW-1:0] junk;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int comp(input logic [DW-1:0] word, input int l, input int im);
        logic [9:0] v;
        v = word[l*20 + ((im != 0) ? 0 : 10) +: 10];
        return int'($signed(v));
    endfunction

    // Expected lane error counts and first error for words 1..nw-1 (word 0 is the lock word).
    function automatic void model(input int nw, input int tol,
                                  output logic [63:0] le, output logic [63:0] fe);
        int cnt [L];
        bit have;
        le   = '0;
        fe   = '0;
        have = 1'b0;
        for (int l = 0; l < L; l++) cnt[l] = 0;
        for (int w = 1; w < nw; w++) begin
            for (int l = 0; l < L; l++) begin
                bit bad;
                bad = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    int d;
                    d = comp(dutw[w], l, c) - comp(gold[w], l, c);
                    if (d < 0) d = -d;
                    if (d > tol) bad = 1'b1;
                end
                if (bad) begin
                    cnt[l]++;
                    if (!have) begin
                        have = 1'b1;
                        fe = {15'd0, 7'(w * L + l), 2'(l), dutw[w][l*20 +: 20], gold[w][l*20 +: 20]};
                    end
                end
            end
        end
        for (int l = 0; l < L; l++) le[l*16 +: 16] = 16'(cnt[l]);
    endfunction

    task automatic make_stream();
        logic [95:0] t;
        for (int w = 0; w < NW; w++) begin
            t = {$urandom, $urandom, $urandom};
            gold[w] = t[DW-1:0];
            dutw[w] = t[DW-1:0];
        end
        // Lane 0 real MSB flipped: differs from golden word 0 by 512, beyond any TOL used here.
        junk = gold[0] ^ (80'd1 << 19);
    endtask

    task automatic corrupt(input int w, input int l, input int im, input int delta);
        int base;
        logic [9:0] v;
        base = l * 20 + ((im != 0) ? 0 : 10);
        v = dutw[w][base +: 10];
        v = v + 10'(delta);
        dutw[w][base +: 10] = v;
    endtask

    task automatic check_zero(input string name);
        chk({name, "/rdy0"}, 64'(rdy0), 64'd0);
        chk({name, "/lk0"},  64'(lk0),  64'd0);
        chk({name, "/dn0"},  64'(dn0),  64'd0);
        chk({name, "/fl0"},  64'(fl0),  64'd0);
        chk({name, "/lat0"}, 64'(lat0), 64'd0);
        chk({name, "/le0"},  64'(le0),  64'd0);
        chk({name, "/fc0"},  64'(fc0),  64'd0);
        chk({name, "/fe0"},  64'(fe0),  64'd0);
        chk({name, "/lk1"},  64'(lk1),  64'd0);
        chk({name, "/le1"},  64'(le1),  64'd0);
    endtask

    // DUT stream lags golden by D cycles (counted from the first SEARCH cycle); D >= MAX_LAT
    // means the DUT never produces golden word 0. Stops early after cycle stop_at.
    task automatic run_scenario(input string name, input int D, input int nw, input int stop_at);
        bit lockable;
        int K, j, wi;
        logic [63:0] le_e0, fe_e0, le_e1, fe_e1;
        lockable = (D < MAX_LAT);
        K = lockable ? D + nw + 4 : MAX_LAT + 6;
        start     = 1'b1;
        exp_valid = 1'b0;
        dut_data  = junk;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= K && k <= stop_at; k++) begin
            j  = k - D;
            wi = (j < 0) ? 0 : j;
            dut_data  = (j >= 0 && j < nw) ? dutw[j] : junk;
            exp_valid = (wi < nw);
            exp_data  = (wi < nw) ? gold[wi] : '0;
            @(negedge clk);
            chk({name, "/rdy0"}, 64'(rdy0), 64'(lockable && k >= D && k <= D + nw));
            chk({name, "/rdy1"}, 64'(rdy1), 64'(lockable && k >= D && k <= D + nw));
            chk({name, "/lk0"},  64'(lk0),  64'(lockable && k > D && k <= D + nw));
            chk({name, "/lk1"},  64'(lk1),  64'(lockable && k > D && k <= D + nw));
            chk({name, "/dn0"},  64'(dn0),  64'(lockable && k > D + nw));
            chk({name, "/fl0"},  64'(fl0),  64'(!lockable && k >= MAX_LAT));
            @(posedge clk); #1;
        end
        if (stop_at >= K) begin
            le_e0 = '0; fe_e0 = '0; le_e1 = '0; fe_e1 = '0;
            if (lockable) begin
                model(nw, 0, le_e0, fe_e0);
                model(nw, 1, le_e1, fe_e1);
            end
`ifndef FFT_CHK_FIRST_ERR_EN
            fe_e0 = '0;
            fe_e1 = '0;
`endif
            @(negedge clk);
            chk({name, "/lat0"}, 64'(lat0), 64'(lockable ? D : MAX_LAT));
            chk({name, "/lat1"}, 64'(lat1), 64'(lockable ? D : MAX_LAT));
            chk({name, "/le0"},  64'(le0),  le_e0);
            chk({name, "/le1"},  64'(le1),  le_e1);
            chk({name, "/fc0"},  64'(fc0),  64'(lockable ? nw / (128 / L) : 0));
            chk({name, "/fc1"},  64'(fc1),  64'(lockable ? nw / (128 / L) : 0));
            chk({name, "/fe0"},  64'(fe0),  fe_e0);
            chk({name, "/fe1"},  64'(fe1),  fe_e1);
            chk({name, "/end_dn1"}, 64'(dn1), 64'(lockable));
            chk({name, "/end_fl1"}, 64'(fl1), 64'(!lockable));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int rd, w;
        rst       = 1'b1;
        start     = 1'b0;
        exp_valid = 1'b0;
        dut_data  = '0;
        exp_data  = '0;
        junk      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");
        @(posedge clk); #1;

        // Clean stream, 3 frames, delay 28
        make_stream();
        run_scenario("clean", 28, NW, 100000);

        // Lane 2 imag +1 at word 5: counted at TOL=0, absorbed at TOL=1
        make_stream();
        corrupt(5, 2, 1, 1);
        run_scenario("lane2", 28, NW, 100000);

        // DUT never matches: timeout to FAIL
        make_stream();
        run_scenario("timeout", 1000, NW, 100000);

        // Reset mid-LOCKED, then a fresh start relocks
        make_stream();
        run_scenario("rstmid", 28, NW, 50);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk); #1;
        rst       = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        check_zero("rst_rel");
        @(posedge clk); #1;
        run_scenario("relock", 28, NW, 100000);

        // Random delay and random small corruptions, including a two-lane tie
        make_stream();
        for (int i = 0; i < 4; i++) begin
            rd = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) != 0) rd = -rd;
            corrupt(int'($urandom_range(1, NW - 1)), int'($urandom_range(0, L - 1)),
                    int'($urandom_range(0, 1)), rd);
        end
        w = int'($urandom_range(1, NW - 1));
        corrupt(w, 3, 0, 2);
        corrupt(w, 1, 1, -2);
        run_scenario("random", int'($urandom_range(0, 40)), NW, 100000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
